fu_muldiv: RTL

Parametrised RV32M/RV64M execution unit in the out-of-order backend, sitting behind the mult/div reservation station and driving the CDB arbiter. It provides a fully pipelined multiplier of configurable depth and an iterative radix-2 divider sharing one result port, with tag tracking, output backpressure and branch-flush kill. It succeeds the fixed-width single-shot multiplier unit; operand width, pipeline depth and tag width are parameters.

---
 rtl/fu_muldiv.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/fu_muldiv.sv
// fu_muldiv: RV32M/RV64M execution unit -- pipelined multiplier and iterative radix-2
// divider sharing one result port. Optional build macro: FU_MULDIV_EARLYOUT_EN.
module fu_muldiv #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 3,
    parameter int TAG_BITS   = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [2:0]          funct3,
    input  logic [XLEN-1:0]     rs1_v,
    input  logic [XLEN-1:0]     rs2_v,
    input  logic [TAG_BITS-1:0] tag_in,
    output logic                result_valid,
    input  logic                result_ready,
    output logic [XLEN-1:0]     result_v,
    output logic [TAG_BITS-1:0] tag_out
);

    // Divider states
    //   state | meaning
    //   IDLE  | ready to accept a div-class op
    //   ITER  | one restoring shift-subtract step per cycle, XLEN steps
    //   FIX   | apply quotient/remainder signs and divide-by-zero quotient
    //   DONE  | result held until consumed
    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} div_state_t;

    localparam int TAIL = MUL_STAGES - 1;
    localparam int CW   = $clog2(XLEN);

    // ---------------- issue / handshake ----------------
    logic issue_ok, mul_ready, div_ready, mul_acc, div_acc;
    logic tail_v, sel_mul, sel_div, tail_out, div_consume, div_hold;
    div_state_t dstate, dstate_d;

    logic [MUL_STAGES-1:0] mv, mfree, mld, mout;

    assign issue_ok    = !rst && !flush;
    assign mul_ready   = issue_ok && mfree[0];
    assign div_ready   = issue_ok && (dstate == IDLE);
    assign issue_ready = funct3[2] ? div_ready : mul_ready;
    assign mul_acc     = issue_valid && !funct3[2] && mul_ready;
    assign div_acc     = issue_valid &&  funct3[2] && div_ready;

    // A div result already on the port keeps it until consumed so the port stays stable.
    assign tail_v       = mv[TAIL];
    assign sel_div      = (dstate == DONE) && (!tail_v || div_hold);
    assign sel_mul      = tail_v && !sel_div;
    assign result_valid = issue_ok && (sel_mul || sel_div);
    assign tail_out     = sel_mul && result_ready;
    assign div_consume  = sel_div && result_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) div_hold <= 1'b0;
        else              div_hold <= sel_div && !result_ready;
    end

    // ---------------- multiplier ----------------
    logic                   a_sgn, b_sgn;
    logic signed [2*XLEN+1:0] ma, mb, mul_prod;
    logic [1:0]             unused_prod_hi;
    logic [2*XLEN-1:0]      mprod [MUL_STAGES];
    logic [1:0]             mf3   [MUL_STAGES];
    logic [TAG_BITS-1:0]    mtag  [MUL_STAGES];
    logic [XLEN-1:0]        mul_res;

    assign a_sgn    = (funct3[1:0] != 2'b11);
    assign b_sgn    = !funct3[1];
    assign ma       = {{(XLEN+2){a_sgn & rs1_v[XLEN-1]}}, rs1_v};
    assign mb       = {{(XLEN+2){b_sgn & rs2_v[XLEN-1]}}, rs2_v};
    assign mul_prod = ma * mb;
    assign unused_prod_hi = mul_prod[2*XLEN+1:2*XLEN];

    // Stage k is free if any stage from k to the tail is empty, or the tail drains.
    always_comb begin
        logic full;
        mfree = '0;
        for (int k = 0; k < MUL_STAGES; k++) begin
            full = 1'b1;
            for (int j = k; j < MUL_STAGES; j++) full = full & mv[j];
            mfree[k] = !full || tail_out;
        end
    end

    always_comb begin
        mld    = '0;
        mld[0] = mul_acc;
        for (int k = 1; k < MUL_STAGES; k++) mld[k] = mv[k-1] && mfree[k];
        mout       = '0;
        mout[TAIL] = tail_out;
        for (int k = 0; k < TAIL; k++) mout[k] = mld[k+1];
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            mv <= '0;
        end else begin
            for (int k = 0; k < MUL_STAGES; k++) mv[k] <= mld[k] | (mv[k] & ~mout[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (mld[0]) begin
            mprod[0] <= mul_prod[2*XLEN-1:0];
            mf3[0]   <= funct3[1:0];
            mtag[0]  <= tag_in;
        end
        for (int k = 1; k < MUL_STAGES; k++) begin
            if (mld[k]) begin
                mprod[k] <= mprod[k-1];
                mf3[k]   <= mf3[k-1];
                mtag[k]  <= mtag[k-1];
            end
        end
    end

    assign mul_res = (mf3[TAIL] == 2'b00) ? mprod[TAIL][XLEN-1:0] : mprod[TAIL][2*XLEN-1:XLEN];

    // ---------------- divider ----------------
    logic                d_sgn, sa, sb, div0_in, div_early;
    logic [XLEN-1:0]     abs_a, abs_b, early_res;
    logic [XLEN-1:0]     dr, dq, dd, q_fin, r_fin;
    logic [XLEN:0]       r_sh, r_sub;
    logic                step_ok;
    logic [CW-1:0]       dcnt;
    logic                d_qneg, d_rneg, d_rem, d_div0;
    logic [TAG_BITS-1:0] dtag;

    assign d_sgn   = !funct3[0];
    assign sa      = d_sgn & rs1_v[XLEN-1];
    assign sb      = d_sgn & rs2_v[XLEN-1];
    assign abs_a   = sa ? -rs1_v : rs1_v;
    assign abs_b   = sb ? -rs2_v : rs2_v;
    assign div0_in = (rs2_v == '0);

`ifdef FU_MULDIV_EARLYOUT_EN
    logic ovf_in;
    assign ovf_in    = d_sgn && (rs1_v == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_v == '1);
    assign div_early = div0_in || ovf_in;
    assign early_res = funct3[1] ? (div0_in ? rs1_v : '0) : (div0_in ? '1 : rs1_v);
`else
    assign div_early = 1'b0;
    assign early_res = '0;
`endif

    assign r_sh    = {dr, dq[XLEN-1]};
    assign r_sub   = r_sh - {1'b0, dd};
    assign step_ok = !r_sub[XLEN];
    assign q_fin   = d_div0 ? '1 : (d_qneg ? -dq : dq);
    assign r_fin   = d_rneg ? -dr : dr;

    always_ff @(posedge clk) begin
        if (rst || flush) dstate <= IDLE;
        else              dstate <= dstate_d;
    end

    always_comb begin
        dstate_d = dstate;
        case (dstate)
            IDLE:    if (div_acc) dstate_d = div_early ? DONE : ITER;
            ITER:    if (dcnt == '0) dstate_d = FIX;
            FIX:     dstate_d = DONE;
            DONE:    if (div_consume) dstate_d = IDLE;
            default: dstate_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        case (dstate)
            IDLE: begin
                if (div_acc) begin
                    dr     <= '0;
                    dq     <= div_early ? early_res : abs_a;
                    dd     <= abs_b;
                    dcnt   <= CW'(XLEN - 1);
                    d_qneg <= sa ^ sb;
                    d_rneg <= sa;
                    d_rem  <= funct3[1];
                    d_div0 <= div0_in;
                    dtag   <= tag_in;
                end
            end
            ITER: begin
                dr   <= step_ok ? r_sub[XLEN-1:0] : r_sh[XLEN-1:0];
                dq   <= {dq[XLEN-2:0], step_ok};
                dcnt <= dcnt - CW'(1);
            end
            FIX:     dq <= d_rem ? r_fin : q_fin;
            default: ;
        endcase
    end

    // ---------------- result port ----------------
    always_comb begin
        result_v = '0;
        tag_out  = '0;
        if (result_valid) begin
            if (sel_mul) begin
                result_v = mul_res;
                tag_out  = mtag[TAIL];
            end else begin
                result_v = dq;
                tag_out  = dtag;
            end
        end
    end

endmodule
